multi_cycle_controller: RTL and testbench

Parametrised multi-cycle control unit for the RISC-V core. It replaces the single-cycle decoder with a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over a shared ALU and a unified instruction/data memory. The memory side uses a ready handshake. A watchdog raises a timeout error when memory never answers, and undecodable instructions trap to a sticky error state.

---
 rtl/multi_cycle_controller.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and unified memory, with a memory-wait watchdog and a
// sticky error state for undecodable instructions or timeouts.
module multi_cycle_controller #(
  parameter int unsigned WAIT_LIMIT    = 15,
  parameter bit          STRICT_DECODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       lt,
  input  logic       bge,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       retire,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int unsigned CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_LW   = 7'd3;
  localparam logic [6:0] OP_SW   = 7'd35;
  localparam logic [6:0] OP_BR   = 7'd99;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_JALR = 7'd103;
  localparam logic [6:0] OP_LUI  = 7'd55;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADR, S_MEM_READ,
    S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_JALR, S_LINK, S_LUI, S_ERROR
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    err_q;
  logic [1:0]    err_next;
  logic          timeout;
  logic          legal;
  logic          wait_state;

  // Watchdog fires when the counter reaches the limit and memory still has not answered.
  always_comb begin
    timeout    = (WAIT_LIMIT != 0) && !mem_ready && (wait_cnt == CW'(WAIT_LIMIT));
    wait_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  end

  assign err_code = err_q;

  // State register, wait counter (cleared on every state change) and latched error cause.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      err_q    <= 2'b00;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (wait_state && !mem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (next_state == S_ERROR && state != S_ERROR) begin
        err_q <= err_next;
      end
    end
  end

  // Next-state and control-strobe decode.
  always_comb begin
    next_state = state;
    err_next   = 2'b00;
    legal      = 1'b1;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 3'b000;
    retire     = 1'b0;
    error      = 1'b0;

    case (state)
      S_FETCH: begin
        // State register already sits in FETCH during reset; keep strobes low then.
        if (!rst) begin
          MemRead   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        if (mem_ready) begin
          next_state = S_DECODE;
        end else if (timeout) begin
          next_state = S_ERROR;
          err_next   = ERR_TIMEOUT;
        end
      end

      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (opcode == OP_BR)       ImmSrc = 3'b010;
        else if (opcode == OP_JAL) ImmSrc = 3'b011;
        case (opcode)
          OP_R:          next_state = S_EXEC_R;
          OP_I:          next_state = S_EXEC_I;
          OP_LW, OP_SW:  next_state = S_MEM_ADR;
          OP_BR:         next_state = S_BRANCH;
          OP_JAL:        next_state = S_JUMP;
          OP_JALR:       next_state = S_JALR;
          OP_LUI:        next_state = S_LUI;
          default: begin
            next_state = S_ERROR;
            err_next   = ERR_ILLEGAL;
          end
        endcase
      end

      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        case ({func7, func3})
          10'd0:   ALUControl = 3'b000;
          10'd256: ALUControl = 3'b001;
          10'd4:   ALUControl = 3'b100;
          10'd6:   ALUControl = 3'b011;
          10'd7:   ALUControl = 3'b010;
          10'd2:   ALUControl = 3'b101;
          10'd3:   ALUControl = 3'b110;
          default: legal = 1'b0;
        endcase
        if (legal || !STRICT_DECODE) begin
          next_state = S_ALU_WB;
        end else begin
          next_state = S_ERROR;
          err_next   = ERR_ILLEGAL;
        end
      end

      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        case (func3)
          3'b000:  ALUControl = 3'b000;
          3'b100:  ALUControl = 3'b100;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          3'b010:  ALUControl = 3'b101;
          3'b011:  ALUControl = 3'b110;
          default: legal = 1'b0;
        endcase
        if (legal || !STRICT_DECODE) begin
          next_state = S_ALU_WB;
        end else begin
          next_state = S_ERROR;
          err_next   = ERR_ILLEGAL;
        end
      end

      S_ALU_WB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_MEM_ADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (opcode == OP_SW) ImmSrc = 3'b001;
        if (func3 == 3'b010 || !STRICT_DECODE) begin
          next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        end else begin
          next_state = S_ERROR;
          err_next   = ERR_ILLEGAL;
        end
      end

      S_MEM_READ: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) begin
          next_state = S_MEM_WB;
        end else if (timeout) begin
          next_state = S_ERROR;
          err_next   = ERR_TIMEOUT;
        end
      end

      S_MEM_WB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_MEM_WRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (timeout) begin
          next_state = S_ERROR;
          err_next   = ERR_TIMEOUT;
        end
      end

      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        case (func3)
          3'b000:  PCWrite = zero;
          3'b001:  PCWrite = !zero;
          3'b100:  PCWrite = lt;
          3'b101:  PCWrite = bge;
          default: legal = 1'b0;
        endcase
        // Unknown branch kinds always trap, even with relaxed decode.
        if (legal) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end else begin
          next_state = S_ERROR;
          err_next   = ERR_ILLEGAL;
        end
      end

      S_JUMP: begin
        PCWrite    = 1'b1;
        next_state = S_LINK;
      end

      S_JALR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        next_state = S_LINK;
      end

      S_LINK: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_LUI: begin
        ImmSrc     = 3'b100;
        ResultSrc  = 2'b11;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_ERROR: begin
        error      = 1'b1;
        next_state = S_ERROR;
      end

      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller (watchdog limit 4, strict decode).
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero, lt, bge, mem_ready;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic       retire, error;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  wire [21:0] outs = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
                      retire, error, err_code};

  multi_cycle_controller #(.WAIT_LIMIT(4), .STRICT_DECODE(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
    .zero(zero), .lt(lt), .bge(bge), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .retire(retire), .error(error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    opcode = op;
    func3  = f3;
    func7  = f7;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_outs", 32'(outs), 0);
    tick();
    rst       = 1'b0;
    mem_ready = 1'b1;
    #1;
  endtask

  // From FETCH: run an ALU instruction and check its ALU function and writeback.
  task automatic alu_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [2:0] ctl);
    set_instr(op, f3, f7);
    #1;
    tick();
    tick();
    check({tag, "_ctl"}, 32'(ALUControl), 32'(ctl));
    tick();
    check({tag, "_wb"}, 32'({RegWrite, retire}), 3);
    tick();
  endtask

  // From FETCH: run a branch and check the taken decision in the BRANCH cycle.
  task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                            input logic l, input logic g, input logic exp_pc);
    set_instr(7'd99, f3, 7'd0);
    zero = z;
    lt   = l;
    bge  = g;
    #1;
    tick();
    check({tag, "_imm"}, 32'(ImmSrc), 2);
    tick();
    check({tag, "_pcw"}, 32'(PCWrite), 32'(exp_pc));
    check({tag, "_ret"}, 32'({retire, ALUControl}), 32'h9);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    set_instr(7'd0, 3'd0, 7'd0);
    zero = 1'b0; lt = 1'b0; bge = 1'b0; mem_ready = 1'b0;
    #2;
    check("rst_outs", 32'(outs), 0);
    mem_ready = 1'b1;
    #1;
    check("rst_outs_ready", 32'(outs), 0);
    tick();
    rst = 1'b0;
    #1;

    // add: FETCH, DECODE, EXEC_R, ALU_WB
    set_instr(7'd51, 3'd0, 7'd0);
    #1;
    check("add_fetch", 32'({MemRead, IRWrite, PCWrite, AdrSrc}), 32'hE);
    check("add_fetch_mux", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'b00_10_10);
    tick();
    check("add_dec", 32'({ALUSrcA, ALUSrcB, ImmSrc, RegWrite}), 32'b01_01_000_0);
    tick();
    check("add_exec", 32'({ALUSrcA, ALUSrcB, ALUControl, RegWrite, retire}), 32'b10_00_000_0_0);
    tick();
    check("add_wb", 32'({RegWrite, retire, ResultSrc}), 32'b1100);
    tick();
    check("add_next_fetch", 32'({MemRead, RegWrite, retire}), 32'b100);

    alu_op("sub",  7'd51, 3'd0, 7'h20, 3'b001);
    alu_op("and",  7'd51, 3'd7, 7'h00, 3'b010);
    alu_op("sltu", 7'd51, 3'd3, 7'h00, 3'b110);
    alu_op("xori", 7'd19, 3'd4, 7'h00, 3'b100);
    alu_op("slti", 7'd19, 3'd2, 7'h00, 3'b101);

    // lw with three wait cycles in MEM_READ
    set_instr(7'd3, 3'd2, 7'd0);
    #1;
    check("lw_fetch_irw", 32'(IRWrite), 1);
    tick();
    check("lw_dec_imm", 32'(ImmSrc), 0);
    tick();
    check("lw_adr", 32'({ALUSrcA, ALUSrcB, ImmSrc}), 32'b10_01_000);
    tick();
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("lw_wait", 32'({MemRead, AdrSrc, RegWrite, error}), 32'b1100);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_read_done", 32'({MemRead, AdrSrc}), 3);
    tick();
    check("lw_wb", 32'({ResultSrc, RegWrite, retire, MemRead}), 32'b01_1_1_0);
    tick();
    check("lw_next_fetch", 32'(MemRead), 1);

    // branches
    run_branch("beq_t",  3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_branch("bne_nt", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_branch("blt_t",  3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    run_branch("bge_nt", 3'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    set_instr(7'd99, 3'd2, 7'd0);
    zero = 1'b1;
    #1;
    tick();
    tick();
    check("bad_br_strobes", 32'({PCWrite, retire}), 0);
    tick();
    check("bad_br_err", 32'({error, err_code}), 32'b101);
    check("bad_br_outs", 32'(outs), 32'h5);
    tick();
    check("bad_br_sticky", 32'({error, err_code, MemRead}), 32'b1010);
    do_reset();

    // jalr: JALR then LINK
    set_instr(7'd103, 3'd0, 7'd0);
    #1;
    tick();
    tick();
    check("jalr", 32'({PCWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite}), 32'b1_10_10_01_0);
    tick();
    check("link", 32'({RegWrite, ALUSrcA, ALUSrcB, retire, PCWrite, ResultSrc}), 32'b1_01_10_1_0_10);
    tick();

    // watchdog: ready arrives on the limit cycle, no error; then LUI
    set_instr(7'd55, 3'd0, 7'd0);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("wd_wait", 32'({MemRead, IRWrite, error}), 32'b100);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("wd_last_ready", 32'({IRWrite, PCWrite, error}), 32'b110);
    tick();
    check("wd_no_err", 32'(error), 0);
    tick();
    check("lui", 32'({ImmSrc, ResultSrc, RegWrite, retire}), 32'b100_11_1_1);
    tick();

    // watchdog: five FETCH cycles without ready -> timeout
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("to_pre", 32'(error), 0);
      tick();
    end
    check("to_err", 32'(outs), 32'h6);
    mem_ready = 1'b1;
    tick();
    check("to_sticky", 32'(outs), 32'h6);
    do_reset();

    // undefined opcode
    set_instr(7'd0, 3'd0, 7'd0);
    #1;
    tick();
    tick();
    check("op0_err", 32'({error, err_code}), 32'b101);
    do_reset();

    // illegal R-type encoding
    set_instr(7'd51, 3'd1, 7'h20);
    #1;
    tick();
    tick();
    check("badr_no_wb", 32'(RegWrite), 0);
    tick();
    check("badr_err", 32'({error, err_code}), 32'b101);
    do_reset();

    // lw with wrong width
    set_instr(7'd3, 3'd0, 7'd0);
    #1;
    tick();
    tick();
    tick();
    check("lb_err", 32'({error, err_code, MemRead}), 32'b1010);
    do_reset();

    // sw completing normally
    set_instr(7'd35, 3'd2, 7'd0);
    #1;
    tick();
    tick();
    check("sw_imm", 32'(ImmSrc), 1);
    tick();
    mem_ready = 1'b0;
    #1;
    check("sw_wait", 32'({MemWrite, AdrSrc, retire}), 32'b110);
    mem_ready = 1'b1;
    #1;
    check("sw_done", 32'({MemWrite, retire}), 3);
    tick();
    check("sw_next_fetch", 32'({MemWrite, MemRead}), 1);

    // reset pulsed mid-store
    #1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    check("sw2_wait", 32'(MemWrite), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_memw", 32'(MemWrite), 0);
    check("rst_mid_outs", 32'(outs), 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_fetch", 32'({MemRead, AdrSrc, MemWrite, error, err_code}), 32'b100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
